cpu_sequencer: RTL and testbench

Multi-cycle control FSM for the RV32I core. It runs each instruction through fetch, decode, execute, memory and writeback, using the 4-bit instruction class that the decoder derives from the instruction register. It drives the IR, PC, register-file, ALU-operand and memory-port enables. It owns the single shared instruction/data memory port through a req/ready handshake.

---
 rtl/cpu_pkg.sv | 42 ++++
 rtl/seq_perf_counters.sv | 24 ++
 rtl/cpu_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_cpu_sequencer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and encodings for the RV32I multi-cycle sequencer.
// Holds the FSM state enum, decoder class codes and PC/writeback mux selects.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEM       = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_TRAP      = 3'd5
  } seq_state_t;

  localparam logic [3:0] INST_LOAD  = 4'b0001;
  localparam logic [3:0] INST_STORE = 4'b0010;
  localparam logic [3:0] INST_R     = 4'b0011;
  localparam logic [3:0] INST_I     = 4'b0100;
  localparam logic [3:0] INST_BR    = 4'b0101;
  localparam logic [3:0] INST_JAL   = 4'b0110;

  localparam logic [1:0] PC_SEL_PC4 = 2'b00;
  localparam logic [1:0] PC_SEL_IMM = 2'b01;

  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_MEM = 2'b01;
  localparam logic [1:0] WB_SEL_PC4 = 2'b10;

  function automatic logic is_legal_inst(input logic [3:0] t);
    logic legal;
    case (t)
      INST_LOAD, INST_STORE, INST_R, INST_I, INST_BR, INST_JAL: legal = 1'b1;
      default:                                                   legal = 1'b0;
    endcase
    return legal;
  endfunction

  // Classes whose ALU second operand comes from the immediate field.
  function automatic logic uses_imm(input logic [3:0] t);
    return (t == INST_I) || (t == INST_LOAD) || (t == INST_STORE);
  endfunction

endpackage

// File: rtl/seq_perf_counters.sv
// seq_perf_counters: free-running cycle and retired-instruction counters.
// Instantiated by cpu_sequencer only when CPU_SEQ_PERF_CNT_EN is defined.
module seq_perf_counters (
  input  logic        clk,
  input  logic        rst,
  input  logic        retire,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
);

  // Both counters wrap naturally modulo 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt   <= 32'd0;
      instret_cnt <= 32'd0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (retire) begin
        instret_cnt <= instret_cnt + 32'd1;
      end
    end
  end

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle FETCH/DECODE/EXECUTE/MEM/WRITEBACK control FSM for the RV32I core.
// Define CPU_SEQ_PERF_CNT_EN to add the cycle_cnt / instret_cnt performance counter outputs.
module cpu_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  inst_type,
  input  logic        branch_taken,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        alu_b_sel,
  output logic        retire,
  output logic        trap,
  output logic [2:0]  state_o
`ifdef CPU_SEQ_PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
`endif
);
  import cpu_pkg::*;

  seq_state_t state;
  seq_state_t state_nxt;
  logic [3:0] cls;

  logic       mem_req_c;
  logic       mem_we_c;
  logic       mem_addr_sel_c;
  logic       ir_we_c;
  logic       pc_we_c;
  logic [1:0] pc_sel_c;
  logic       rf_we_c;
  logic [1:0] wb_sel_c;
  logic       alu_b_sel_c;
  logic       retire_c;
  logic       trap_c;

  // cls is captured once in DECODE and stays frozen until the next instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_FETCH;
      cls   <= 4'd0;
    end else begin
      state <= state_nxt;
      if (state == ST_DECODE) begin
        cls <= inst_type;
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    mem_req_c      = 1'b0;
    mem_we_c       = 1'b0;
    mem_addr_sel_c = 1'b0;
    ir_we_c        = 1'b0;
    pc_we_c        = 1'b0;
    pc_sel_c       = PC_SEL_PC4;
    rf_we_c        = 1'b0;
    wb_sel_c       = WB_SEL_ALU;
    alu_b_sel_c    = 1'b0;
    retire_c       = 1'b0;
    trap_c         = 1'b0;

    case (state)
      ST_FETCH: begin
        mem_req_c = 1'b1;
        if (mem_ready) begin
          ir_we_c   = 1'b1;
          state_nxt = ST_DECODE;
        end
      end

      ST_DECODE: begin
        state_nxt = is_legal_inst(inst_type) ? ST_EXECUTE : ST_TRAP;
      end

      ST_EXECUTE: begin
        alu_b_sel_c = uses_imm(cls);
        case (cls)
          INST_BR: begin
            pc_we_c   = 1'b1;
            pc_sel_c  = branch_taken ? PC_SEL_IMM : PC_SEL_PC4;
            retire_c  = 1'b1;
            state_nxt = ST_FETCH;
          end
          INST_LOAD, INST_STORE: state_nxt = ST_MEM;
          default:               state_nxt = ST_WRITEBACK;
        endcase
      end

      // Request, address select and write strobe stay stable until mem_ready.
      ST_MEM: begin
        mem_req_c      = 1'b1;
        mem_addr_sel_c = 1'b1;
        mem_we_c       = (cls == INST_STORE);
        if (mem_ready) begin
          if (cls == INST_STORE) begin
            pc_we_c   = 1'b1;
            pc_sel_c  = PC_SEL_PC4;
            retire_c  = 1'b1;
            state_nxt = ST_FETCH;
          end else begin
            state_nxt = ST_WRITEBACK;
          end
        end
      end

      ST_WRITEBACK: begin
        rf_we_c   = 1'b1;
        pc_we_c   = 1'b1;
        retire_c  = 1'b1;
        state_nxt = ST_FETCH;
        case (cls)
          INST_LOAD: wb_sel_c = WB_SEL_MEM;
          INST_JAL: begin
            wb_sel_c = WB_SEL_PC4;
            pc_sel_c = PC_SEL_IMM;
          end
          default:   wb_sel_c = WB_SEL_ALU;
        endcase
      end

      ST_TRAP: begin
        trap_c    = 1'b1;
        state_nxt = ST_TRAP;
      end

      default: begin
        state_nxt = ST_FETCH;
      end
    endcase
  end

  // Reset forces every output low, even while the state register still holds a stale value.
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = 2'b00;
    rf_we        = 1'b0;
    wb_sel       = 2'b00;
    alu_b_sel    = 1'b0;
    retire       = 1'b0;
    trap         = 1'b0;
    state_o      = 3'd0;
    if (!rst) begin
      mem_req      = mem_req_c;
      mem_we       = mem_we_c;
      mem_addr_sel = mem_addr_sel_c;
      ir_we        = ir_we_c;
      pc_we        = pc_we_c;
      pc_sel       = pc_sel_c;
      rf_we        = rf_we_c;
      wb_sel       = wb_sel_c;
      alu_b_sel    = alu_b_sel_c;
      retire       = retire_c;
      trap         = trap_c;
      state_o      = state;
    end
  end

`ifdef CPU_SEQ_PERF_CNT_EN
  seq_perf_counters u_perf (
    .clk         (clk),
    .rst         (rst),
    .retire      (retire),
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
  );
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: randomized self-checking bench for cpu_sequencer against an instruction-level model.
// Perf-counter checks are compiled in when CPU_SEQ_PERF_CNT_EN is defined.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  inst_type = 4'd0;
  logic        branch_taken = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we, rf_we, alu_b_sel, retire, trap;
  logic [1:0]  pc_sel, wb_sel;
  logic [2:0]  state_o;
`ifdef CPU_SEQ_PERF_CNT_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  typedef struct packed {
    logic [2:0] st;
    logic       trap;
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       rf_we;
    logic [1:0] wb_sel;
    logic       alu_b_sel;
    logic       retire;
  } outs_t;

  outs_t act;
  outs_t expCur;
  string expTag = "none";
  logic  expValid = 1'b0;
  int    tests = 0;
  int    failed = 0;
  int    cycleNo = 0;
  int    lastRetire = -1;

  cpu_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .inst_type    (inst_type),
    .branch_taken (branch_taken),
    .mem_ready    (mem_ready),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr_sel (mem_addr_sel),
    .ir_we        (ir_we),
    .pc_we        (pc_we),
    .pc_sel       (pc_sel),
    .rf_we        (rf_we),
    .wb_sel       (wb_sel),
    .alu_b_sel    (alu_b_sel),
    .retire       (retire),
    .trap         (trap),
    .state_o      (state_o)
`ifdef CPU_SEQ_PERF_CNT_EN
    ,
    .cycle_cnt    (cycle_cnt),
    .instret_cnt  (instret_cnt)
`endif
  );

  always #5 clk = ~clk;

  assign act = {state_o, trap, mem_req, mem_we, mem_addr_sel, ir_we, pc_we,
                pc_sel, rf_we, wb_sel, alu_b_sel, retire};

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  // One compare process: every cycle with a model expectation is checked on the falling edge.
  always @(negedge clk) begin
    if (expValid) begin
      checkOutput($sformatf("%s@cycle%0d", expTag, cycleNo), 32'(act), 32'(expCur));
      if (retire === 1'b1) lastRetire = cycleNo;
    end
  end

  function automatic logic [3:0] rnd4();
    return 4'($urandom_range(0, 15));
  endfunction

  function automatic logic rnd1();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic outs_t idle(input logic [2:0] st);
    outs_t o;
    o = '0;
    o.st = st;
    return o;
  endfunction

  function automatic logic legal(input logic [3:0] c);
    return (c >= 4'd1) && (c <= 4'd6);
  endfunction

  task automatic applyStimulus(input logic r, input logic [3:0] it, input logic bt,
                               input logic mr, input outs_t e, input string tag);
    @(posedge clk);
    #1;
    rst          = r;
    inst_type    = it;
    branch_taken = bt;
    mem_ready    = mr;
    expCur       = e;
    expTag       = tag;
    expValid     = 1'b1;
    cycleNo++;
  endtask

  // Instruction-level model: walks one instruction through its phases and states what each cycle must show.
  task automatic runInstr(input logic [3:0] c, input int fw, input int mw,
                          input logic tk, input int trapCycles);
    outs_t e;
    for (int i = 0; i <= fw; i++) begin
      e = idle(3'd0);
      e.mem_req = 1'b1;
      e.ir_we = (i == fw);
      applyStimulus(1'b0, rnd4(), rnd1(), (i == fw), e, "fetch");
    end
    e = idle(3'd1);
    applyStimulus(1'b0, c, rnd1(), rnd1(), e, "decode");
    if (!legal(c)) begin
      for (int i = 0; i < trapCycles; i++) begin
        e = idle(3'd5);
        e.trap = 1'b1;
        applyStimulus(1'b0, rnd4(), rnd1(), rnd1(), e, "trap");
      end
    end else begin
      e = idle(3'd2);
      e.alu_b_sel = (c == 4'd1) || (c == 4'd2) || (c == 4'd4);
      if (c == 4'd5) begin
        e.pc_we = 1'b1;
        e.pc_sel = tk ? 2'b01 : 2'b00;
        e.retire = 1'b1;
      end
      applyStimulus(1'b0, rnd4(), tk, rnd1(), e, "execute");
      if (c == 4'd1 || c == 4'd2) begin
        for (int i = 0; i <= mw; i++) begin
          e = idle(3'd3);
          e.mem_req = 1'b1;
          e.mem_addr_sel = 1'b1;
          e.mem_we = (c == 4'd2);
          if (i == mw && c == 4'd2) begin
            e.pc_we = 1'b1;
            e.retire = 1'b1;
          end
          applyStimulus(1'b0, rnd4(), rnd1(), (i == mw), e, "mem");
        end
      end
      if (c != 4'd5 && c != 4'd2) begin
        e = idle(3'd4);
        e.rf_we = 1'b1;
        e.pc_we = 1'b1;
        e.retire = 1'b1;
        e.wb_sel = (c == 4'd1) ? 2'b01 : (c == 4'd6) ? 2'b10 : 2'b00;
        e.pc_sel = (c == 4'd6) ? 2'b01 : 2'b00;
        applyStimulus(1'b0, rnd4(), rnd1(), rnd1(), e, "writeback");
      end
    end
  endtask

  // Runs one instruction and checks the DUT retire cycle against a hand-computed instruction length.
  task automatic timedInstr(input string name, input logic [3:0] c, input int fw,
                            input int mw, input logic tk, input int lenWant);
    int start;
    start = cycleNo + 1;
    lastRetire = -1;
    runInstr(c, fw, mw, tk, 0);
    @(negedge clk);
    #1;
    checkOutput(name, 32'(lastRetire - start + 1), 32'(lenWant));
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    outs_t e;
    int c;

    for (int i = 0; i < 3; i++) applyStimulus(1'b1, rnd4(), rnd1(), rnd1(), idle(3'd0), "reset");

    timedInstr("len_ralu",   4'd3, 0, 0, 1'b0, 4);
    timedInstr("len_ialu",   4'd4, 0, 0, 1'b0, 4);
    timedInstr("len_jal",    4'd6, 0, 0, 1'b0, 4);
    timedInstr("len_br_tk",  4'd5, 0, 0, 1'b1, 3);
    timedInstr("len_br_nt",  4'd5, 0, 0, 1'b0, 3);
    timedInstr("len_store",  4'd2, 0, 0, 1'b0, 4);
    timedInstr("len_load",   4'd1, 0, 0, 1'b0, 5);
    timedInstr("len_load_w", 4'd1, 2, 1, 1'b0, 8);
    timedInstr("len_store_w", 4'd2, 0, 3, 1'b0, 7);

    runInstr(4'd7, 0, 0, 1'b0, 10);
    @(negedge clk);
    #1;
    checkOutput("trap_sticky", 32'(trap), 32'd1);
    applyStimulus(1'b1, rnd4(), rnd1(), rnd1(), idle(3'd0), "reset_trap");
    timedInstr("len_after_trap", 4'd3, 0, 0, 1'b0, 4);

    // Reset while a load is stalled in MEM: the request is dropped with no retire.
    runInstr(4'd3, 0, 0, 1'b0, 0);
    e = idle(3'd0); e.mem_req = 1'b1; e.ir_we = 1'b1;
    applyStimulus(1'b0, rnd4(), 1'b0, 1'b1, e, "abort_fetch");
    applyStimulus(1'b0, 4'd1, 1'b0, 1'b0, idle(3'd1), "abort_decode");
    e = idle(3'd2); e.alu_b_sel = 1'b1;
    applyStimulus(1'b0, rnd4(), 1'b0, 1'b0, e, "abort_execute");
    e = idle(3'd3); e.mem_req = 1'b1; e.mem_addr_sel = 1'b1;
    applyStimulus(1'b0, rnd4(), 1'b0, 1'b0, e, "abort_mem");
    applyStimulus(1'b0, rnd4(), 1'b0, 1'b0, e, "abort_mem");
    applyStimulus(1'b1, rnd4(), 1'b0, 1'b1, idle(3'd0), "abort_reset");
    timedInstr("len_after_abort", 4'd1, 0, 0, 1'b0, 5);

    for (int n = 0; n < 250; n++) begin
      c = $urandom_range(0, 19);
      if (c < 18) begin
        runInstr(4'(1 + (c % 6)), $urandom_range(0, 3), $urandom_range(0, 3), rnd1(), 0);
      end else begin
        do c = $urandom_range(0, 15); while (legal(4'(c)));
        runInstr(4'(c), $urandom_range(0, 2), 0, 1'b0, $urandom_range(1, 5));
        applyStimulus(1'b1, rnd4(), rnd1(), rnd1(), idle(3'd0), "reset_rand");
      end
      if ($urandom_range(0, 29) == 0) begin
        applyStimulus(1'b1, rnd4(), rnd1(), rnd1(), idle(3'd0), "reset_rand");
      end
    end

`ifdef CPU_SEQ_PERF_CNT_EN
    applyStimulus(1'b1, rnd4(), rnd1(), rnd1(), idle(3'd0), "reset_perf");
    for (int i = 0; i < 3; i++) runInstr(4'd6, 0, 0, 1'b0, 0);
    e = idle(3'd0); e.mem_req = 1'b1;
    applyStimulus(1'b0, rnd4(), 1'b0, 1'b0, e, "perf_hold");
    @(negedge clk);
    #1;
    checkOutput("instret_cnt", instret_cnt, 32'd3);
    checkOutput("cycle_cnt", cycle_cnt, 32'd12);
    expValid = 1'b0;
    force dut.u_perf.cycle_cnt = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    release dut.u_perf.cycle_cnt;
    @(negedge clk);
    checkOutput("cycle_cnt_forced", cycle_cnt, 32'hFFFFFFFF);
    @(negedge clk);
    checkOutput("cycle_cnt_wrap", cycle_cnt, 32'd0);
`endif

    @(negedge clk);
    expValid = 1'b0;
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
